// File: rtl/pll_lock_supervisor_if.sv
// PLL supervisor signal bundle: lock/request inputs, PLL/system resets, status and diagnostics.
// The supervisor connects through the slave modport; the environment or PLL wrapper uses master.
interface pll_lock_supervisor_if;
  logic       pll_locked;
  logic       reset_req;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [1:0] state;
  logic [7:0] retry_count;
  logic [7:0] lost_count;

  modport master (
    output pll_locked, reset_req,
    input  pll_rst, sys_reset, ready, state, retry_count, lost_count
  );

  modport slave (
    input  pll_locked, reset_req,
    output pll_rst, sys_reset, ready, state, retry_count, lost_count
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset/lock and holds sys_reset until lock is stable. Lock is seen 2 cycles late through the synchronizer;
// outputs are registered with state and there is no backpressure. Optional RUN dropout filter: LOCK_GLITCH_FILTER_EN.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 500000,
  parameter int unsigned LOCK_STABLE_CYCLES = 50000,
  parameter int unsigned GLITCH_CYCLES      = 8
) (
  input logic                   refclk,
  input logic                   rst,
  pll_lock_supervisor_if.slave  bus
);

  typedef enum logic [1:0] {
    PLL_RESET = 2'd0,
    WAIT_LOCK = 2'd1,
    STABILIZE = 2'd2,
    RUN       = 2'd3
  } state_e;

  localparam logic [23:0] RST_LOAD     = 24'(PLL_RST_CYCLES - 1);
  localparam logic [23:0] TIMEOUT_LOAD = 24'(LOCK_TIMEOUT - 1);
  localparam logic [23:0] STABLE_LOAD  = 24'(LOCK_STABLE_CYCLES - 1);

  if (PLL_RST_CYCLES < 1 || PLL_RST_CYCLES > 24'hFFFFFF ||
      LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 24'hFFFFFF ||
      LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > 24'hFFFFFF ||
      GLITCH_CYCLES < 1 || GLITCH_CYCLES > 255) begin : g_param_check
    $error("pll_lock_supervisor: parameter out of range");
  end

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  lost_q, lost_d;
  logic        sync1_q, lk_q;
  logic        pll_rst_q, sys_reset_q, ready_q;
  logic        lk;

`ifdef LOCK_GLITCH_FILTER_EN
  localparam logic [7:0] GLITCH_LAST = 8'(GLITCH_CYCLES - 1);
  logic [7:0] glitch_q, glitch_d;
`endif

  assign lk = lk_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = lost_q;
`ifdef LOCK_GLITCH_FILTER_EN
    glitch_d = '0;
`endif
    if (bus.reset_req) begin
      state_d = PLL_RESET;
      cnt_d   = RST_LOAD;
    end else begin
      unique case (state_q)
        PLL_RESET: begin
          if (cnt_q == '0) begin
            state_d = WAIT_LOCK;
            cnt_d   = TIMEOUT_LOAD;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        WAIT_LOCK: begin
          // A lock seen on the timeout cycle takes priority over the retry.
          if (lk) begin
            state_d = STABILIZE;
            cnt_d   = STABLE_LOAD;
          end else if (cnt_q == '0) begin
            state_d = PLL_RESET;
            cnt_d   = RST_LOAD;
            if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        STABILIZE: begin
          if (!lk) begin
            state_d = WAIT_LOCK;
            cnt_d   = TIMEOUT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        RUN: begin
`ifdef LOCK_GLITCH_FILTER_EN
          // Only a dropout of GLITCH_CYCLES consecutive unlocked cycles counts as a loss.
          if (!lk) begin
            if (glitch_q == GLITCH_LAST) begin
              state_d = PLL_RESET;
              cnt_d   = RST_LOAD;
              if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
            end else begin
              glitch_d = glitch_q + 8'd1;
            end
          end
`else
          if (!lk) begin
            state_d = PLL_RESET;
            cnt_d   = RST_LOAD;
            if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
          end
`endif
        end
        default: begin
          state_d = PLL_RESET;
          cnt_d   = RST_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= PLL_RESET;
      cnt_q       <= RST_LOAD;
      retry_q     <= '0;
      lost_q      <= '0;
      sync1_q     <= 1'b0;
      lk_q        <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      ready_q     <= 1'b0;
`ifdef LOCK_GLITCH_FILTER_EN
      glitch_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      sync1_q     <= bus.pll_locked;
      lk_q        <= sync1_q;
      // Decoded from the next state so the outputs move on the same edge as state.
      pll_rst_q   <= (state_d == PLL_RESET);
      sys_reset_q <= (state_d != RUN);
      ready_q     <= (state_d == RUN);
`ifdef LOCK_GLITCH_FILTER_EN
      glitch_q    <= glitch_d;
`endif
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_reset   = sys_reset_q;
  assign bus.ready       = ready_q;
  assign bus.state       = state_q;
  assign bus.retry_count = retry_q;
  assign bus.lost_count  = lost_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with short timing parameters; inputs change 1 time unit after the rising edge.
// Expected values are cycle counts worked out by hand from the sequencing rules.
module tb_pll_lock_supervisor;
  logic refclk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT       (20),
    .LOCK_STABLE_CYCLES (10),
    .GLITCH_CYCLES      (3)
  ) dut (
    .refclk (refclk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},     32'(bus.state),       32'd0);
    chk({tag, "_pll_rst"},   32'(bus.pll_rst),     32'd1);
    chk({tag, "_sys_reset"}, 32'(bus.sys_reset),   32'd1);
    chk({tag, "_ready"},     32'(bus.ready),       32'd0);
    chk({tag, "_retry"},     32'(bus.retry_count), 32'd0);
    chk({tag, "_lost"},      32'(bus.lost_count),  32'd0);
  endtask

  initial begin
    bus.pll_locked = 1'b0;
    bus.reset_req  = 1'b0;
    rst            = 1'b1;
    tick(2);
    chk_reset_vals("rst");

    // Power-up: pll_rst for 4 cycles, lock raised on WAIT_LOCK entry, 10 stable cycles to RUN.
    rst = 1'b0;
    tick(3);
    chk("pu_prst_state", 32'(bus.state), 32'd0);
    chk("pu_prst_pin",   32'(bus.pll_rst), 32'd1);
    tick(1);
    chk("pu_wait_state", 32'(bus.state), 32'd1);
    chk("pu_wait_pin",   32'(bus.pll_rst), 32'd0);
    bus.pll_locked = 1'b1;
    tick(2);
    chk("pu_sync_lag", 32'(bus.state), 32'd1);
    tick(1);
    chk("pu_stab_entry", 32'(bus.state), 32'd2);
    tick(9);
    chk("pu_stab_last", 32'(bus.state), 32'd2);
    chk("pu_stab_sysrst", 32'(bus.sys_reset), 32'd1);
    tick(1);
    chk("pu_run_state", 32'(bus.state), 32'd3);
    chk("pu_run_sysrst", 32'(bus.sys_reset), 32'd0);
    chk("pu_run_ready", 32'(bus.ready), 32'd1);

    // Lock loss in RUN.
`ifdef LOCK_GLITCH_FILTER_EN
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(2);
    chk("glitch1_state", 32'(bus.state), 32'd3);
    chk("glitch1_sysrst", 32'(bus.sys_reset), 32'd0);
    tick(3);
    chk("glitch1_hold", 32'(bus.state), 32'd3);
    chk("glitch1_lost", 32'(bus.lost_count), 32'd0);
    bus.pll_locked = 1'b0;
    tick(3);
    bus.pll_locked = 1'b1;
    tick(1);
    chk("glitch3_pre", 32'(bus.state), 32'd3);
    tick(1);
    chk("glitch3_state", 32'(bus.state), 32'd0);
    chk("glitch3_sysrst", 32'(bus.sys_reset), 32'd1);
    chk("glitch3_lost", 32'(bus.lost_count), 32'd1);
`else
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(1);
    chk("loss_pre", 32'(bus.state), 32'd3);
    tick(1);
    chk("loss_state", 32'(bus.state), 32'd0);
    chk("loss_sysrst", 32'(bus.sys_reset), 32'd1);
    chk("loss_pllrst", 32'(bus.pll_rst), 32'd1);
    chk("loss_lost", 32'(bus.lost_count), 32'd1);
`endif
    tick(14);
    chk("relock_stab", 32'(bus.state), 32'd2);
    tick(1);
    chk("relock_run", 32'(bus.state), 32'd3);

    // One-cycle reset_req in RUN.
    bus.reset_req = 1'b1;
    tick(1);
    chk("req1_state", 32'(bus.state), 32'd0);
    chk("req1_pllrst", 32'(bus.pll_rst), 32'd1);
    chk("req1_ready", 32'(bus.ready), 32'd0);
    bus.reset_req = 1'b0;
    tick(3);
    chk("req1_prst_end", 32'(bus.state), 32'd0);
    tick(1);
    chk("req1_wait", 32'(bus.state), 32'd1);
    chk("req1_lost", 32'(bus.lost_count), 32'd1);
    chk("req1_retry", 32'(bus.retry_count), 32'd0);

    // reset_req held 10 cycles from STABILIZE: pll_rst for 10+4 cycles.
    tick(1);
    chk("reqh_stab", 32'(bus.state), 32'd2);
    bus.reset_req = 1'b1;
    tick(10);
    chk("reqh_held", 32'(bus.state), 32'd0);
    bus.reset_req = 1'b0;
    tick(3);
    chk("reqh_tail", 32'(bus.pll_rst), 32'd1);
    tick(1);
    chk("reqh_wait", 32'(bus.state), 32'd1);
    chk("reqh_pllrst", 32'(bus.pll_rst), 32'd0);

    // One-cycle lock dropout at STABILIZE cycle 6, then a full 10-cycle re-qualification.
    tick(1);
    chk("stab_entry", 32'(bus.state), 32'd2);
    tick(5);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(1);
    chk("stabdrop_lag", 32'(bus.state), 32'd2);
    tick(1);
    chk("stabdrop_wait", 32'(bus.state), 32'd1);
    chk("stabdrop_retry", 32'(bus.retry_count), 32'd0);
    chk("stabdrop_lost", 32'(bus.lost_count), 32'd1);
    tick(1);
    chk("stabdrop_restab", 32'(bus.state), 32'd2);
    tick(9);
    chk("stabdrop_last", 32'(bus.state), 32'd2);
    tick(1);
    chk("stabdrop_run", 32'(bus.state), 32'd3);

    // Two lock timeouts: 4 PLL_RESET + 20 WAIT_LOCK cycles each.
    bus.pll_locked = 1'b0;
    bus.reset_req  = 1'b1;
    tick(1);
    bus.reset_req  = 1'b0;
    tick(3);
    chk("to_prst", 32'(bus.state), 32'd0);
    tick(1);
    chk("to_wait", 32'(bus.state), 32'd1);
    tick(19);
    chk("to_wait_last", 32'(bus.state), 32'd1);
    chk("to_retry0", 32'(bus.retry_count), 32'd0);
    tick(1);
    chk("to_retry_state", 32'(bus.state), 32'd0);
    chk("to_retry1", 32'(bus.retry_count), 32'd1);
    tick(23);
    chk("to2_wait", 32'(bus.state), 32'd1);
    tick(1);
    chk("to2_state", 32'(bus.state), 32'd0);
    chk("to2_retry2", 32'(bus.retry_count), 32'd2);

    // Asynchronous reset in the middle of STABILIZE.
    bus.pll_locked = 1'b1;
    tick(5);
    chk("arst_stab", 32'(bus.state), 32'd2);
    chk("arst_retry", 32'(bus.retry_count), 32'd2);
    tick(3);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("arst");

    // Retry counter saturation with lock held low.
    bus.pll_locked = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(4);
    chk("sat_wait", 32'(bus.state), 32'd1);
    tick(19);
    chk("sat_retry0", 32'(bus.retry_count), 32'd0);
    tick(1);
    chk("sat_retry1", 32'(bus.retry_count), 32'd1);
    tick(253 * 24);
    chk("sat_retry254", 32'(bus.retry_count), 32'd254);
    tick(24);
    chk("sat_retry255", 32'(bus.retry_count), 32'd255);
    chk("sat_state", 32'(bus.state), 32'd0);
    tick(46 * 24);
    chk("sat_hold", 32'(bus.retry_count), 32'd255);
    chk("sat_lost", 32'(bus.lost_count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
